fetch_stage: RTL



---
 rtl/rv32i_types.sv | 24 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the front end: IF/ID bundle, fetch-buffer entry, NOP.
// Helper sat_inc backs the optional FETCH_PERF_EN counters.
package rv32i_types;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
    } if_id_stage_reg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic        en
    );
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, inst} between imem and IF/ID.
// Flush empties it in one cycle; entries are never bypassed.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_pop;

    assign do_pop = pop && !empty;
    assign full   = (count == DEPTH_C);
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    // Storage array; written only on push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem reads, fetch buffer, IF/ID.
// Define FETCH_PERF_EN to add saturating perf counters.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h1ECE_B000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       imem_addr,
    output logic [3:0]        imem_rmask,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_resp,
    input  logic              stall_signal,
    input  logic              freeze_stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output if_id_stage_reg_t  if_id,
    output logic [31:0]       imem_rdata_id
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   out_pc;
    logic          epoch;
    logic          out_epoch;
    logic          outstanding;
    logic          advance;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          full;
    logic          empty;
    fetch_entry_t  head;

    assign advance = !(stall_signal | freeze_stall);
    assign pop     = advance && !empty && !redirect;
    assign push    = imem_resp && outstanding && (out_epoch == epoch)
                     && !redirect && (!full || pop);

    assign count_after = count + CW'(push) - CW'(pop);

    // Space is reserved at issue time so the eventual push always fits.
    assign issue = rst && (!outstanding || imem_resp) && !redirect
                   && (count_after < DEPTH_C);

    assign imem_rmask = issue ? 4'hF : 4'h0;
    assign imem_addr  = issue ? fetch_pc : 32'h0;

    fetch_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ('{pc: out_pc, inst: imem_rdata}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // PC and outstanding-request tracking; a redirect retires the epoch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            epoch       <= 1'b0;
            outstanding <= 1'b0;
            out_epoch   <= 1'b0;
            out_pc      <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            if (outstanding && !imem_resp && (out_epoch == epoch)) begin
                epoch <= !epoch;
            end
            if (imem_resp) begin
                outstanding <= 1'b0;
            end
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 32'd4;
            outstanding <= 1'b1;
            out_epoch   <= epoch;
            out_pc      <= fetch_pc;
        end else if (imem_resp) begin
            outstanding <= 1'b0;
        end
    end

    // IF/ID register: squash on redirect, hold on stall, else take head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id         <= '{pc: 32'h0, valid: 1'b0};
            imem_rdata_id <= NOP;
        end else if (redirect) begin
            if_id.valid   <= 1'b0;
            imem_rdata_id <= NOP;
        end else if (advance) begin
            if (!empty) begin
                if_id         <= '{pc: head.pc, valid: 1'b1};
                imem_rdata_id <= head.inst;
            end else begin
                if_id.valid   <= 1'b0;
                imem_rdata_id <= NOP;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic drop;
    logic held;

    assign drop = imem_resp && outstanding && !push;
    assign held = !redirect && !advance && if_id.valid;

    // Saturating event counters for pushes, drops and held-valid cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched      <= '0;
            perf_dropped      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_fetched      <= sat_inc(perf_fetched, push);
            perf_dropped      <= sat_inc(perf_dropped, drop);
            perf_stall_cycles <= sat_inc(perf_stall_cycles, held);
        end
    end
`endif

endmodule
